// File: rtl/ofs_fim_pcie_ss_txreq_arb.sv
// ofs_fim_pcie_ss_txreq_arb
// Merges two header-only AXI-S sources (DM MRd reads and interrupts) onto the
// PCIe SS txreq channel. Arbitration is round-robin. The output is a single
// register stage that can reload in the same cycle it drains. Per-source
// saturating counters and a sticky multi-beat error flag support debug.
module ofs_fim_pcie_ss_txreq_arb #(
   parameter int TDATA_W = 256,
   parameter int TUSER_W = 10,
   parameter int CNT_W   = 16
) (
   input  logic               fim_clk,
   input  logic               fim_rst_n,

   input  logic               rd_tvalid,
   input  logic               rd_tlast,
   input  logic [TDATA_W-1:0] rd_tdata,
   input  logic [TUSER_W-1:0] rd_tuser_vendor,
   output logic               rd_tready,

   input  logic               intr_tvalid,
   input  logic               intr_tlast,
   input  logic [TDATA_W-1:0] intr_tdata,
   input  logic [TUSER_W-1:0] intr_tuser_vendor,
   output logic               intr_tready,

   output logic               txreq_tvalid,
   output logic               txreq_tlast,
   output logic [TDATA_W-1:0] txreq_tdata,
   output logic [TUSER_W-1:0] txreq_tuser_vendor,
   input  logic               txreq_tready,

   input  logic               clr_cnt,
   output logic [CNT_W-1:0]   rd_cnt,
   output logic [CNT_W-1:0]   intr_cnt,
   output logic               err_multi_beat
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t              r_state, w_state_nxt;
   logic                r_prio_intr;   // 1: intr wins the next tie
   logic [TDATA_W-1:0]  r_tdata;
   logic [TUSER_W-1:0]  r_tuser;
   logic [CNT_W-1:0]    r_rd_cnt, r_intr_cnt;
   logic                r_err;

   logic                w_slot_free, w_gnt_rd, w_gnt_intr;
   logic                w_acc_rd, w_acc_intr, w_acc, w_acc_tlast;
   logic                w_load, w_bad;

   // Slot can take a header when empty or when the held one leaves this cycle.
   assign w_slot_free = (r_state == EMPTY) | txreq_tready;
   assign w_gnt_rd    = rd_tvalid   & (~intr_tvalid | ~r_prio_intr);
   assign w_gnt_intr  = intr_tvalid & (~rd_tvalid   |  r_prio_intr);

   // Gating with reset keeps both sources stalled while reset is held.
   assign rd_tready   = fim_rst_n & w_slot_free & w_gnt_rd;
   assign intr_tready = fim_rst_n & w_slot_free & w_gnt_intr;

   assign w_acc_rd    = rd_tready;
   assign w_acc_intr  = intr_tready;
   assign w_acc       = w_acc_rd | w_acc_intr;
   assign w_acc_tlast = w_acc_rd ? rd_tlast : intr_tlast;
   // A tlast=0 beat is swallowed: it frees the source but never reaches txreq.
   assign w_load      = w_acc &  w_acc_tlast;
   assign w_bad       = w_acc & ~w_acc_tlast;

   // State register for the output slot.
   always_ff @(posedge fim_clk) begin
      if (!fim_rst_n) r_state <= EMPTY;
      else            r_state <= w_state_nxt;
   end

   // Next-state: load wins over drain so back-to-back headers stay full.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         EMPTY: if (w_load) w_state_nxt = FULL;
         FULL:  if (txreq_tready && !w_load) w_state_nxt = EMPTY;
         default: w_state_nxt = EMPTY;
      endcase
   end

   // Output decode: every forwarded header is a single beat.
   always_comb begin
      txreq_tvalid = (r_state == FULL);
      txreq_tlast  = (r_state == FULL);
   end

   // Payload capture; only written on a load, so it holds under backpressure.
   always_ff @(posedge fim_clk) begin
      if (w_load) begin
         r_tdata <= w_acc_rd ? rd_tdata        : intr_tdata;
         r_tuser <= w_acc_rd ? rd_tuser_vendor : intr_tuser_vendor;
      end
   end

   assign txreq_tdata        = r_tdata;
   assign txreq_tuser_vendor = r_tuser;

   // Round-robin pointer moves only when a beat is actually accepted.
   always_ff @(posedge fim_clk) begin
      if (!fim_rst_n)      r_prio_intr <= 1'b0;
      else if (w_acc_rd)   r_prio_intr <= 1'b1;
      else if (w_acc_intr) r_prio_intr <= 1'b0;
   end

   // Saturating per-source counters and sticky error; clear has priority.
   always_ff @(posedge fim_clk) begin
      if (!fim_rst_n || clr_cnt) begin
         r_rd_cnt   <= '0;
         r_intr_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         if (w_load && w_acc_rd && (r_rd_cnt != '1))
            r_rd_cnt <= r_rd_cnt + CNT_W'(1);
         if (w_load && w_acc_intr && (r_intr_cnt != '1))
            r_intr_cnt <= r_intr_cnt + CNT_W'(1);
         if (w_bad)
            r_err <= 1'b1;
      end
   end

   assign rd_cnt         = r_rd_cnt;
   assign intr_cnt       = r_intr_cnt;
   assign err_multi_beat = r_err;

endmodule
